pattern_gen: RTL and testbench
==============================

# pattern_gen

Parametrised multi-lane video test-pattern generator for the LVDS panel path. It takes the pixel coordinate from the LVDS serialiser timing and returns CHANNELS pixel colours per clock, one per LVDS lane (odd/even today). It adds selectable patterns, frame-synchronous mode switching and frame-counter animation to the fixed x/y gradient. It runs in the pixel-clock domain (the divided LVDS clock).

## Interface
Parameters:
- CHANNELS, 2: pixels produced per clock; lane k shows pixel x+k.
- COORD_W, 12: width of x/y coordinates.
- COMP_W, 8: bits per colour component; colour word is {R,G,B}, 3*COMP_W bits.
- H_ACTIVE, 1024: active width; pixels with x+k ≥ H_ACTIVE are black.
- V_ACTIVE, 600: active height; pixels with y ≥ V_ACTIVE are black.
- BAR_LOG2, 7: log2 of colour-bar width in pixels.
- CHECK_LOG2, 5: log2 of checkerboard square size.

Ports:
- i_clk  in  1  pixel clock; the block's only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  coordinate valid this cycle.
- i_frame_start  in  1  first pixel of a frame; meaningful only with i_valid.
- i_x  in  COORD_W  x of lane 0.
- i_y  in  COORD_W  line number.
- i_mode  in  3  requested pattern; sampled only at frame start.
- i_solid  in  3*COMP_W  colour for SOLID mode.
- o_valid  out  1  o_color valid.
- o_color  out  CHANNELS*3*COMP_W  lane k at bits [(k+1)*3*COMP_W-1 : k*3*COMP_W].

## Operation
- Modes:
  - 0 SOLID: i_solid, sampled in stage 1.
  - 1 GRADIENT: R = x[COMP_W-1:0], G = y[COMP_W-1:0], B = 0.
  - 2 BARS: index = min(x>>BAR_LOG2, 7) selects white, yellow, cyan, green, magenta, red, blue, black.
  - 3 CHECKER: white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
  - 4 GRAY: R = G = B = x[COMP_W-1:0].
  - 5 MOVING: R = (x+F) mod 2^COMP_W, G = (y+F) mod 2^COMP_W, B = F[COMP_W-1:0].
  - 6, 7: black.
- "Full" component means all ones; x in the mode formulas is the per-lane x+k.
- Active-mode register r_mode latches i_mode when i_valid & i_frame_start. That same pixel already uses the new mode. i_mode is ignored at all other times.
- 8-bit frame counter F increments (mod 256) on i_valid & i_frame_start. The frame-start pixel uses the incremented value, so the first frame after reset has F = 1.
- Per-lane x+k is computed at COORD_W+1 bits; no wrap into range. Any out-of-range pixel outputs 0 in every mode.
- Cycles with i_valid = 0 change no state except pipeline valid bits; i_frame_start is ignored when i_valid = 0.

## Timing
- Two-stage pipeline, latency 2:
  - Stage 1 registers per-lane coordinate, effective mode, F and i_solid.
  - Stage 2 registers o_color.
- o_valid is i_valid delayed 2 cycles.
- Throughput: one CHANNELS-wide pixel group per clock, no stalls, no backpressure.
- o_color holds its last value while o_valid = 0.
- Reset values: o_valid = 0, o_color = 0, r_mode = 0 (SOLID), F = 0, all pipeline valids 0.
- Reset mid-frame: in-flight pixels are dropped. Output resumes 2 cycles after the first i_valid following release. Mode stays SOLID until the next frame start.
- Mode change mid-frame: takes effect at the next i_frame_start only; no tearing.
- F wraps 255 → 0 with no glitch.

## Structure
- Package pattern_pkg holds:
  - mode constants MODE_SOLID … MODE_MOVING;
  - the 8-entry bar colour table, parametrised on COMP_W;
  - a colour-assembly helper.
- Sub-module pattern_pixel: combinational colour for one lane from (x, y, mode, F, solid). It is instantiated CHANNELS times from a generate loop between stage 1 and stage 2.
- pattern_gen holds r_mode, F, the pipeline registers and the range checks.

## Test plan
- Reset, then i_valid with i_frame_start, mode 0, i_solid = 24'h123456 -> o_valid at +2 cycles; both lanes 24'h123456.
- Frame start with mode 1, x = 10, y = 3 -> lane 0 = 24'h0A0300, lane 1 = 24'h0B0300.
- Mode 2, x = 128 -> lane 0 yellow 24'hFFFF00. x = 1022 -> lane 0 and lane 1 black 24'h000000 (index saturates at 7). x = 1023 -> lane 1 black (out of range).
- Running in mode 1, drive i_mode = 3 mid-frame -> output stays gradient until the next i_frame_start. That pixel at (0,0) is black; x = 32, y = 0 -> white.
- Mode 5, 256 frame starts -> the frame-start pixel at (0,0) shows B = 1, 2, …, 255, 0 (wrap). Pixel (0,0) on frame 3 -> 24'h030303.
- Assert i_reset for 1 cycle mid-stream -> o_valid = 0 and o_color = 0 the next cycle. Mode is SOLID and F = 0 until the next frame start.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the LVDS test-pattern generator: mode encodings,
// colour-bar table and colour packing helpers.
package pattern_pkg;

  localparam int unsigned FRAME_W     = 8;
  localparam int unsigned MAX_COMP_W  = 16;
  localparam int unsigned MAX_COLOR_W = 3 * MAX_COMP_W;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_GRADIENT = 3'd1,
    MODE_BARS     = 3'd2,
    MODE_CHECKER  = 3'd3,
    MODE_GRAY     = 3'd4,
    MODE_MOVING   = 3'd5,
    MODE_BLACK6   = 3'd6,
    MODE_BLACK7   = 3'd7
  } mode_e;

  // Frame-level state carried alongside each pixel group through stage 1.
  typedef struct packed {
    mode_e              mode;
    logic [FRAME_W-1:0] frame;
  } s1_meta_t;

  typedef logic [MAX_COMP_W-1:0]  comp_t;
  typedef logic [MAX_COLOR_W-1:0] color_t;

  // Bar order white..black as {R,G,B} full/zero flags.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic comp_t full_comp(input int unsigned comp_w);
    return comp_t'((32'd1 << comp_w) - 32'd1);
  endfunction

  // Packs three comp_w-wide components into {R,G,B} in the low 3*comp_w bits.
  function automatic color_t pack_rgb(input comp_t r, input comp_t g,
                                      input comp_t b, input int unsigned comp_w);
    color_t c;
    c = (color_t'(r) << (2 * comp_w)) | (color_t'(g) << comp_w) | color_t'(b);
    return c;
  endfunction

  function automatic color_t bar_color(input logic [2:0] idx,
                                       input int unsigned comp_w);
    logic [2:0] f;
    comp_t      full;
    f    = BAR_RGB[idx];
    full = full_comp(comp_w);
    return pack_rgb(f[2] ? full : '0, f[1] ? full : '0, f[0] ? full : '0, comp_w);
  endfunction

endpackage

// File: rtl/pattern_pixel.sv
// Combinational colour of one lane from its coordinate, mode and frame count.
module pattern_pixel
  import pattern_pkg::*;
#(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned COMP_W     = 8,
  parameter int unsigned BAR_LOG2   = 7,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic [COORD_W:0]     i_x,
  input  logic [COORD_W-1:0]   i_y,
  input  mode_e                i_mode,
  input  logic [FRAME_W-1:0]   i_frame,
  input  logic [3*COMP_W-1:0]  i_solid,
  output logic [3*COMP_W-1:0]  o_color_c
);

  localparam int unsigned X_W     = COORD_W + 1;
  localparam int unsigned COLOR_W = 3 * COMP_W;

  logic [COMP_W-1:0] w_xc;
  logic [COMP_W-1:0] w_yc;
  logic [COMP_W-1:0] w_fc;
  logic [COMP_W-1:0] w_mov_r;
  logic [COMP_W-1:0] w_mov_g;
  logic [X_W-1:0]    w_bar_raw;
  logic [2:0]        w_bar_idx;
  logic              w_check;
  comp_t             w_full;
  logic              w_unused_y;

  assign w_xc      = COMP_W'(i_x);
  assign w_yc      = COMP_W'(i_y);
  assign w_fc      = COMP_W'(i_frame);
  assign w_mov_r   = w_xc + w_fc;
  assign w_mov_g   = w_yc + w_fc;
  // Bar index saturates at the last (black) bar for wide panels.
  assign w_bar_raw = i_x >> BAR_LOG2;
  assign w_bar_idx = (w_bar_raw > X_W'(7)) ? 3'd7 : 3'(w_bar_raw);
  assign w_check   = i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2];
  assign w_full    = full_comp(COMP_W);
  assign w_unused_y = ^i_y;

  always_comb begin
    o_color_c = '0;
    case (i_mode)
      MODE_SOLID:    o_color_c = i_solid;
      MODE_GRADIENT: o_color_c = COLOR_W'(pack_rgb(comp_t'(w_xc), comp_t'(w_yc),
                                                   '0, COMP_W));
      MODE_BARS:     o_color_c = COLOR_W'(bar_color(w_bar_idx, COMP_W));
      MODE_CHECKER:  o_color_c = w_check ? COLOR_W'(pack_rgb(w_full, w_full, w_full, COMP_W))
                                         : '0;
      MODE_GRAY:     o_color_c = COLOR_W'(pack_rgb(comp_t'(w_xc), comp_t'(w_xc),
                                                   comp_t'(w_xc), COMP_W));
      MODE_MOVING:   o_color_c = COLOR_W'(pack_rgb(comp_t'(w_mov_r), comp_t'(w_mov_g),
                                                   comp_t'(w_fc), COMP_W));
      default:       o_color_c = '0;
    endcase
  end

endmodule

// File: rtl/pattern_gen.sv
// Multi-lane test-pattern generator: frame-synchronous mode latch, frame
// counter, per-lane range checks and a two-stage colour pipeline.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned COMP_W     = 8,
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned BAR_LOG2   = 7,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic                           i_frame_start,
  input  logic [COORD_W-1:0]             i_x,
  input  logic [COORD_W-1:0]             i_y,
  input  logic [2:0]                     i_mode,
  input  logic [3*COMP_W-1:0]            i_solid,
  output logic                           o_valid,
  output logic [CHANNELS*3*COMP_W-1:0]   o_color
);

  localparam int unsigned X_W     = COORD_W + 1;
  localparam int unsigned COLOR_W = 3 * COMP_W;

  mode_e              r_mode;
  logic [FRAME_W-1:0] r_frame;

  logic               r_s1_valid;
  logic [X_W-1:0]     r_s1_x [CHANNELS];
  logic [COORD_W-1:0] r_s1_y;
  s1_meta_t           r_s1_meta;
  logic [COLOR_W-1:0] r_s1_solid;
  logic [CHANNELS-1:0] r_s1_in_range;

  logic               w_fs;
  s1_meta_t           w_meta;
  logic               w_y_ok;
  logic [X_W-1:0]     w_lane_x [CHANNELS];
  logic [CHANNELS-1:0] w_in_range;
  logic [COLOR_W-1:0] w_pix [CHANNELS];
  logic [CHANNELS*COLOR_W-1:0] w_color;

  assign w_fs   = i_valid & i_frame_start;
  assign w_y_ok = i_y < COORD_W'(V_ACTIVE);

  // The frame-start pixel already sees the new mode and incremented count.
  always_comb begin
    w_meta.mode  = r_mode;
    w_meta.frame = r_frame;
    if (w_fs) begin
      w_meta.mode  = mode_e'(i_mode);
      w_meta.frame = r_frame + FRAME_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    assign w_lane_x[k]   = X_W'(i_x) + X_W'(k);
    assign w_in_range[k] = w_y_ok && (w_lane_x[k] < X_W'(H_ACTIVE));

    pattern_pixel #(
      .COORD_W    (COORD_W),
      .COMP_W     (COMP_W),
      .BAR_LOG2   (BAR_LOG2),
      .CHECK_LOG2 (CHECK_LOG2)
    ) u_pixel (
      .i_x       (r_s1_x[k]),
      .i_y       (r_s1_y),
      .i_mode    (r_s1_meta.mode),
      .i_frame   (r_s1_meta.frame),
      .i_solid   (r_s1_solid),
      .o_color_c (w_pix[k])
    );

    assign w_color[k*COLOR_W +: COLOR_W] = r_s1_in_range[k] ? w_pix[k] : '0;
  end

  // Frame state, stage 1 and stage 2; data registers hold while invalid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode        <= MODE_SOLID;
      r_frame       <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_y        <= '0;
      r_s1_meta     <= '0;
      r_s1_solid    <= '0;
      r_s1_in_range <= '0;
      for (int k = 0; k < CHANNELS; k++) r_s1_x[k] <= '0;
      o_valid       <= 1'b0;
      o_color       <= '0;
    end else begin
      r_s1_valid <= i_valid;
      o_valid    <= r_s1_valid;
      if (w_fs) begin
        r_mode  <= w_meta.mode;
        r_frame <= w_meta.frame;
      end
      if (i_valid) begin
        r_s1_y        <= i_y;
        r_s1_meta     <= w_meta;
        r_s1_solid    <= i_solid;
        r_s1_in_range <= w_in_range;
        for (int k = 0; k < CHANNELS; k++) r_s1_x[k] <= w_lane_x[k];
      end
      if (r_s1_valid) begin
        o_color <= w_color;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed, table-driven check of pattern_gen with two lanes and default geometry.
module tb_pattern_gen;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_frame_start;
  logic [11:0] i_x;
  logic [11:0] i_y;
  logic [2:0]  i_mode;
  logic [23:0] i_solid;
  logic        o_valid;
  logic [47:0] o_color;

  int checks = 0;
  int errors = 0;

  pattern_gen dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_frame_start (i_frame_start),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_mode        (i_mode),
    .i_solid       (i_solid),
    .o_valid       (o_valid),
    .o_color       (o_color)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  mode;
    logic [23:0] solid;
    logic        chk;
    logic        ev;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  vec_t p0, p1;
  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic v, input logic fs,
                              input int x, input int y, input int m,
                              input logic [23:0] s, input logic ev,
                              input logic [23:0] e0, input logic [23:0] e1);
    vec_t r;
    r.name = n; r.valid = v; r.fs = fs; r.x = 12'(x); r.y = 12'(y);
    r.mode = 3'(m); r.solid = s; r.chk = 1'b1; r.ev = ev; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  function automatic vec_t idle();
    vec_t r;
    r = mk("idle", 1'b0, 1'b0, 0, 0, 0, 24'h0, 1'b0, 24'h0, 24'h0);
    r.chk = 1'b0;
    return r;
  endfunction

  // Compares the record driven two cycles earlier, then drives the new one.
  task automatic apply(input vec_t r);
    @(negedge i_clk);
    if (p0.chk) begin
      checks++;
      if (o_valid !== p0.ev) begin
        errors++;
        $display("FAIL %s o_valid: got %0b expected %0b", p0.name, o_valid, p0.ev);
      end
      checks++;
      if (o_color !== {p0.e1, p0.e0}) begin
        errors++;
        $display("FAIL %s o_color: got %h expected %h", p0.name, o_color, {p0.e1, p0.e0});
      end
    end
    p0 = p1;
    p1 = r;
    i_valid = r.valid; i_frame_start = r.fs; i_x = r.x; i_y = r.y;
    i_mode = r.mode; i_solid = r.solid;
  endtask

  task automatic flush();
    apply(idle());
    apply(idle());
  endtask

  task automatic do_reset(input string n);
    @(negedge i_clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_frame_start = 1'b0;
    p0 = idle();
    p1 = idle();
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s reset o_valid: got %0b expected 0", n, o_valid);
    end
    checks++;
    if (o_color !== 48'h0) begin
      errors++;
      $display("FAIL %s reset o_color: got %h expected 0", n, o_color);
    end
    i_reset = 1'b0;
  endtask

  initial begin
    logic [7:0] f;
    i_reset = 1'b1; i_valid = 1'b0; i_frame_start = 1'b0;
    i_x = '0; i_y = '0; i_mode = '0; i_solid = '0;
    p0 = idle(); p1 = idle();

    tbl.push_back(mk("solid_fs",     1, 1,   0,   0, 0, 24'h123456, 1, 24'h123456, 24'h123456));
    tbl.push_back(mk("solid_ignmode",1, 0,   2,   0, 1, 24'h123456, 1, 24'h123456, 24'h123456));
    tbl.push_back(mk("grad_fs",      1, 1,  10,   3, 1, 24'h0,      1, 24'h0A0300, 24'h0B0300));
    tbl.push_back(mk("grad_req3",    1, 0,  12,   3, 3, 24'h0,      1, 24'h0C0300, 24'h0D0300));
    tbl.push_back(mk("idle_hold",    0, 0,   0,   0, 3, 24'h0,      0, 24'h0C0300, 24'h0D0300));
    tbl.push_back(mk("fs_no_valid",  0, 1,  32,   0, 3, 24'h0,      0, 24'h0C0300, 24'h0D0300));
    tbl.push_back(mk("grad_still",   1, 0,  32,   0, 3, 24'h0,      1, 24'h200000, 24'h210000));
    tbl.push_back(mk("chk_fs",       1, 1,   0,   0, 3, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("chk_white",    1, 0,  32,   0, 3, 24'h0,      1, 24'hFFFFFF, 24'hFFFFFF));
    tbl.push_back(mk("chk_diag",     1, 0,  32,  32, 3, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("chk_edge",     1, 0,  31,   0, 3, 24'h0,      1, 24'h000000, 24'hFFFFFF));
    tbl.push_back(mk("bars_fs",      1, 1, 128,   0, 2, 24'h0,      1, 24'hFFFF00, 24'hFFFF00));
    tbl.push_back(mk("bars_white",   1, 0,   0,   0, 2, 24'h0,      1, 24'hFFFFFF, 24'hFFFFFF));
    tbl.push_back(mk("bars_edge",    1, 0, 255,   0, 2, 24'h0,      1, 24'hFFFF00, 24'h00FFFF));
    tbl.push_back(mk("bars_red",     1, 0, 640,   0, 2, 24'h0,      1, 24'hFF0000, 24'hFF0000));
    tbl.push_back(mk("bars_blue",    1, 0, 768,   0, 2, 24'h0,      1, 24'h0000FF, 24'h0000FF));
    tbl.push_back(mk("bars_sat",     1, 0,1022,   0, 2, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("bars_oor",     1, 0,1023,   0, 2, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("gray_fs",      1, 1,1023,   5, 4, 24'h0,      1, 24'hFFFFFF, 24'h000000));
    tbl.push_back(mk("gray_mid",     1, 0, 200, 599, 4, 24'h0,      1, 24'hC8C8C8, 24'hC9C9C9));
    tbl.push_back(mk("gray_ybot",    1, 0, 200, 600, 4, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("gray_wrap",    1, 0, 640,   0, 4, 24'h0,      1, 24'h808080, 24'h818181));
    tbl.push_back(mk("black6_fs",    1, 1,   4,   4, 6, 24'h0,      1, 24'h000000, 24'h000000));
    tbl.push_back(mk("mov_fs",       1, 1,   0,   0, 5, 24'h0,      1, 24'h070707, 24'h080707));
    tbl.push_back(mk("mov_mid",      1, 0, 250,  10, 5, 24'h0,      1, 24'h011107, 24'h021107));
    tbl.push_back(mk("mov_oor",      1, 0,1023,  10, 5, 24'h0,      1, 24'h061107, 24'h000000));
    tbl.push_back(mk("solid2_fs",    1, 1, 100,   0, 0, 24'hABCDEF, 1, 24'hABCDEF, 24'hABCDEF));
    tbl.push_back(mk("solid_resamp", 1, 0, 100,   0, 0, 24'h00FF00, 1, 24'h00FF00, 24'h00FF00));
    tbl.push_back(mk("solid_yoor",   1, 0, 100, 600, 0, 24'h00FF00, 1, 24'h000000, 24'h000000));

    do_reset("initial");
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Mid-stream reset: in-flight pixels dropped, mode back to SOLID, F back to 0.
    apply(mk("pre_rst_a", 1, 1, 0, 0, 4, 24'h0, 1, 24'h0, 24'h0));
    apply(mk("pre_rst_b", 1, 0, 8, 0, 4, 24'h0, 1, 24'h0, 24'h0));
    do_reset("midstream");
    apply(mk("post_rst_solid", 1, 0, 0, 0, 5, 24'h445566, 1, 24'h445566, 24'h445566));
    apply(mk("post_rst_f1",    1, 1, 0, 0, 5, 24'h0,      1, 24'h010101, 24'h020101));
    flush();

    // Frame counter sweep through wrap in MOVING mode.
    do_reset("pre_sweep");
    for (int n = 1; n <= 256; n++) begin
      f = 8'(n);
      apply(mk($sformatf("mov_frame%0d", n), 1, 1, 0, 0, 5, 24'h0, 1,
               {f, f, f}, {f + 8'd1, f, f}));
    end
    apply(mk("mov_after_wrap", 1, 1, 0, 0, 5, 24'h0, 1, 24'h010101, 24'h020101));
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
